// File: rtl/hdc_char_encoder_if.sv
// Character-in / hypervector-out stream bundle for the HDC character encoder.
// master = upstream/downstream side, slave = encoder.
interface hdc_char_encoder_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_char;
  logic         in_last;
  logic         hv_valid;
  logic         hv_ready;
  logic [W-1:0] hv_data;
  logic         hv_last;
  logic [15:0]  char_count;
  logic         overflow;

  modport master (
    output in_valid, in_char, in_last, hv_ready,
    input  in_ready, hv_valid, hv_data, hv_last, char_count, overflow
  );

  modport slave (
    input  in_valid, in_char, in_last, hv_ready,
    output in_ready, hv_valid, hv_data, hv_last, char_count, overflow
  );
endinterface

// File: rtl/hdc_char_encoder.sv
// Streaming HDC character encoder: tokenize, bundle item HVs into counters, threshold and stream out.
// Optional HDC_SKIP_OTHER_EN: non-alphanumeric characters are accepted but neither bundled nor counted.
module hdc_char_encoder #(
  parameter int unsigned DIM     = 1024,
  parameter int unsigned W       = 32,
  parameter int unsigned MAX_LEN = 160,
  parameter int unsigned CW      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  hdc_char_encoder_if.slave bus_io
);
  localparam int unsigned NW   = DIM / W;
  localparam int unsigned KW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned DW   = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned SW   = $clog2(MAX_LEN * DIM + 1);
  localparam int unsigned CMPW = CW + DW + 1;
  localparam int unsigned PCW  = $clog2(W + 1);
  localparam int unsigned TW   = 6;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   tok_q, tok_d;
  logic            last_q, last_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   cnt_q [DIM];
  logic [CW-1:0]   cnt_d [DIM];
  logic [SW-1:0]   sum_q, sum_d;
  logic [15:0]     cc_q, cc_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            hv_valid_q, hv_valid_d;
  logic            hv_last_q, hv_last_d;
  logic [W-1:0]    hv_data_q, hv_data_d;
  logic [TW-1:0]   in_tok;

  // Case-folded token: a-z -> 11..36, 0-9 -> 1..10, anything else -> 0.
  function automatic logic [TW-1:0] tokenize(input logic [7:0] c);
    logic [7:0] lc;
    lc = (c >= 8'h41 && c <= 8'h5A) ? (c | 8'h20) : c;
    if (lc >= 8'h61 && lc <= 8'h7A) return TW'(lc - 8'h61 + 8'd11);
    if (c >= 8'h30 && c <= 8'h39)   return TW'(c - 8'h30 + 8'd1);
    return TW'(0);
  endfunction

  // Item hypervector bit, regenerated on the fly instead of stored.
  function automatic logic item_bit(input logic [TW-1:0] t, input logic [31:0] d);
    logic [31:0] h;
    h = (d * 32'h9E3779B1) ^ (32'(t) * 32'h85EBCA6B);
    h = h ^ (h >> 15);
    return h[31];
  endfunction

  assign in_tok = tokenize(bus_io.in_char);

  always_comb begin
    int unsigned      base_q;
    int unsigned      base_d;
    logic [DW-1:0]    idx;
    logic [PCW-1:0]   pop;
    logic             b;
    state_d   = state_q;
    tok_d     = tok_q;
    last_d    = last_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cc_d      = cc_q;
    ovf_d     = ovf_q;
    hv_data_d = '0;
    base_q    = 32'(k_q) * W;
    base_d    = 32'd0;
    idx       = '0;
    pop       = '0;
    b         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus_io.in_valid && in_ready_q) begin
          if (cc_q == 16'(MAX_LEN)) begin
            ovf_d = 1'b1;
            if (bus_io.in_last) state_d = S_OUT;
          end
`ifdef HDC_SKIP_OTHER_EN
          else if (in_tok == TW'(0)) begin
            if (bus_io.in_last) state_d = S_OUT;
          end
`endif
          else begin
            tok_d   = in_tok;
            last_d  = bus_io.in_last;
            cc_d    = cc_q + 16'd1;
            k_d     = '0;
            state_d = S_ACC;
          end
        end
      end

      S_ACC: begin
        for (int j = 0; j < int'(W); j++) begin
          idx        = DW'(base_q + 32'(j));
          b          = item_bit(tok_q, 32'(idx));
          cnt_d[idx] = cnt_q[idx] + CW'(b);
          pop        = pop + PCW'(b);
        end
        sum_d = sum_q + SW'(pop);
        if (k_q == KW'(NW - 1)) begin
          k_d     = '0;
          state_d = last_q ? S_OUT : S_IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end

      S_OUT: begin
        if (hv_valid_q && bus_io.hv_ready) begin
          for (int j = 0; j < int'(W); j++) begin
            idx        = DW'(base_q + 32'(j));
            cnt_d[idx] = '0;
          end
          if (k_q == KW'(NW - 1)) begin
            k_d     = '0;
            sum_d   = '0;
            cc_d    = '0;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    hv_valid_d = (state_d == S_OUT);
    hv_last_d  = hv_valid_d && (k_d == KW'(NW - 1));

    // Threshold against the mean without dividing: cnt*DIM > sum.
    if (hv_valid_d) begin
      base_d = 32'(k_d) * W;
      for (int j = 0; j < int'(W); j++) begin
        idx          = DW'(base_d + 32'(j));
        hv_data_d[j] = (CMPW'(cnt_d[idx]) * CMPW'(DIM)) > CMPW'(sum_d);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tok_q      <= '0;
      last_q     <= 1'b0;
      k_q        <= '0;
      cnt_q      <= '{default: '0};
      sum_q      <= '0;
      cc_q       <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b1;
      hv_valid_q <= 1'b0;
      hv_last_q  <= 1'b0;
      hv_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tok_q      <= tok_d;
      last_q     <= last_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      cc_q       <= cc_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
      hv_valid_q <= hv_valid_d;
      hv_last_q  <= hv_last_d;
      hv_data_q  <= hv_data_d;
    end
  end

  assign bus_io.in_ready   = in_ready_q;
  assign bus_io.hv_valid   = hv_valid_q;
  assign bus_io.hv_data    = hv_data_q;
  assign bus_io.hv_last    = hv_last_q;
  assign bus_io.char_count = cc_q;
  assign bus_io.overflow   = ovf_q;
endmodule
